puf_challenge_sequencer: RTL and testbench

PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

---
 rtl/puf_ctrl_pkg.sv | 20 ++
 rtl/puf_watchdog.sv | 32 +++
 rtl/puf_challenge_sequencer.sv | 170 +++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF challenge sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default parameter values used by the top level
package puf_ctrl_pkg;

  localparam int unsigned DEF_TOT_CNT_BITS   = 32;
  localparam int unsigned DEF_CHALLENGE_BITS = 4;
  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_BITS_PER_CH    = 8;
  localparam int unsigned DEF_TIMEOUT_BITS   = 24;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    NEXT,
    OUT
  } state_t;

endpackage

// File: rtl/puf_watchdog.sv
// Down-counting inactivity watchdog.
//   clk, reset : clock, asynchronous active-low reset
//   load       : reload counter to all-ones
//   tick       : count down one step
//   expired    : asserted on the tick that completes 2**WIDTH-1 counted cycles
module puf_watchdog #(
  parameter int unsigned WIDTH = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '1;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // The load value is itself the first counted cycle, so expiry fires while
  // the count still reads 1.
  assign expired = tick && (cnt <= WIDTH'(1));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Issues a run of consecutive challenges to a counter-based PUF, turns each
// pair of counter responses into one key bit and hands the key to the host.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : host key request handshake
//   req_first_ch        : first challenge, sampled on request handshake
//   abort               : synchronous cancel, returns to IDLE
//   start_puf, challenge: PUF launch pulse and challenge
//   puf_response, store_response_puf, puf_done : PUF results
//   key_valid/key_ready : key output handshake
//   key_data, key_error : key (first bit in MSB) and error flag
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned TOT_CNT_BITS   = DEF_TOT_CNT_BITS,
  parameter int unsigned CHALLENGE_BITS = DEF_CHALLENGE_BITS,
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned BITS_PER_CH    = DEF_BITS_PER_CH,
  parameter int unsigned TIMEOUT_BITS   = DEF_TIMEOUT_BITS,
  localparam int unsigned KEY_BITS      = NUM_CH * BITS_PER_CH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CHALLENGE_BITS-1:0] req_first_ch,
  input  logic                      abort,
  output logic                      start_puf,
  output logic [CHALLENGE_BITS-1:0] challenge,
  input  logic [TOT_CNT_BITS-1:0]   puf_response,
  input  logic                      store_response_puf,
  input  logic                      puf_done,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic [KEY_BITS-1:0]       key_data,
  output logic                      key_error
);

  localparam int unsigned BC_W = $clog2(BITS_PER_CH + 1);
  localparam int unsigned CC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                    state, state_n;
  logic [CHALLENGE_BITS-1:0] cur_ch, cur_ch_n;
  logic [KEY_BITS-1:0]       key, key_n;
  logic                      error, error_n;
  logic [CC_W-1:0]           ch_cnt, ch_cnt_n;
  logic [BC_W-1:0]           bit_cnt, bit_cnt_n;
  logic                      phase, phase_n;
  logic [TOT_CNT_BITS-1:0]   a_reg, a_reg_n;
  logic                      wd_load, wd_tick, wd_expired;

  puf_watchdog #(
    .WIDTH (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur_ch  <= '0;
      key     <= '0;
      error   <= 1'b0;
      ch_cnt  <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      a_reg   <= '0;
    end else begin
      state   <= state_n;
      cur_ch  <= cur_ch_n;
      key     <= key_n;
      error   <= error_n;
      ch_cnt  <= ch_cnt_n;
      bit_cnt <= bit_cnt_n;
      phase   <= phase_n;
      a_reg   <= a_reg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_ch_n  = cur_ch;
    key_n     = key;
    error_n   = error;
    ch_cnt_n  = ch_cnt;
    bit_cnt_n = bit_cnt;
    phase_n   = phase;
    a_reg_n   = a_reg;
    wd_load   = 1'b0;

    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_ch_n  = req_first_ch;
            key_n     = '0;
            error_n   = 1'b0;
            ch_cnt_n  = '0;
            bit_cnt_n = '0;
            phase_n   = 1'b0;
            state_n   = LAUNCH;
          end
        end
        LAUNCH: begin
          wd_load = 1'b1;
          state_n = RUN;
        end
        RUN: begin
          // Store is applied to the *_n copies first so that a coincident
          // done pulse judges completeness on the updated counts.
          if (store_response_puf) begin
            wd_load = 1'b1;
            if (bit_cnt == BC_W'(BITS_PER_CH)) begin
              error_n = 1'b1;
            end else if (!phase) begin
              a_reg_n = puf_response;
              phase_n = 1'b1;
            end else begin
              key_n     = key << 1;
              key_n[0]  = (a_reg > puf_response);
              bit_cnt_n = bit_cnt + BC_W'(1);
              phase_n   = 1'b0;
            end
          end
          if (puf_done) begin
            wd_load = 1'b1;
            if ((bit_cnt_n != BC_W'(BITS_PER_CH)) || phase_n) begin
              error_n = 1'b1;
              state_n = OUT;
            end else if (ch_cnt == CC_W'(NUM_CH - 1)) begin
              state_n = OUT;
            end else begin
              state_n = NEXT;
            end
          end else if (!store_response_puf && wd_expired) begin
            error_n = 1'b1;
            state_n = OUT;
          end
        end
        NEXT: begin
          cur_ch_n  = cur_ch + CHALLENGE_BITS'(1);
          ch_cnt_n  = ch_cnt + CC_W'(1);
          bit_cnt_n = '0;
          phase_n   = 1'b0;
          state_n   = LAUNCH;
        end
        OUT: begin
          if (key_ready) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign wd_tick   = (state == RUN);
  assign req_ready = (state == IDLE);
  assign start_puf = (state == LAUNCH) && !abort;
  assign challenge = cur_ch;
  assign key_valid = (state == OUT);
  assign key_data  = key;
  assign key_error = error && (state == OUT);

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_first_ch;
  logic        abort;
  logic        start_puf;
  logic [3:0]  challenge;
  logic [15:0] puf_response;
  logic        store_response_puf;
  logic        puf_done;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_data;
  logic        key_error;

  puf_challenge_sequencer #(
    .TOT_CNT_BITS   (16),
    .CHALLENGE_BITS (4),
    .NUM_CH         (2),
    .BITS_PER_CH    (2),
    .TIMEOUT_BITS   (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_first_ch       (req_first_ch),
    .abort              (abort),
    .start_puf          (start_puf),
    .challenge          (challenge),
    .puf_response       (puf_response),
    .store_response_puf (store_response_puf),
    .puf_done           (puf_done),
    .key_valid          (key_valid),
    .key_ready          (key_ready),
    .key_data           (key_data),
    .key_error          (key_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  // Inputs change on negedges, so start_puf is settled at the rising edge.
  always @(posedge clk) if (reset && start_puf) start_cnt++;

  typedef struct packed {
    logic [3:0]        first;
    logic [0:7][15:0]  resp;
    logic [3:0]        key;
    logic [3:0]        ch0;
    logic [3:0]        ch1;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_store(input logic [15:0] v);
    store_response_puf = 1'b1;
    puf_response = v;
    tick();
    store_response_puf = 1'b0;
  endtask

  task automatic pulse_done();
    puf_done = 1'b1;
    tick();
    puf_done = 1'b0;
  endtask

  task automatic request(input logic [3:0] ch);
    check("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_first_ch = ch;
    tick();
    req_valid = 1'b0;
  endtask

  // Leaves the bench at the first RUN negedge.
  task automatic wait_start(input logic [3:0] exp_ch);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (start_puf === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("start_puf_seen", found, 1);
    check("challenge_launch", challenge, exp_ch);
    tick();
    check("challenge_run", challenge, exp_ch);
  endtask

  task automatic wait_key();
    for (int i = 0; i < 40; i++) begin
      if (key_valid === 1'b1) break;
      tick();
    end
    check("key_valid_rise", key_valid, 1);
  endtask

  task automatic release_key();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("key_valid_after_accept", key_valid, 0);
    check("key_error_after_accept", key_error, 0);
    check("req_ready_after_accept", req_ready, 1);
  endtask

  initial begin
    int s;
    int n;
    logic seen;

    vecs[0] = '{first: 4'd3,
                resp: {16'd10, 16'd5, 16'd5, 16'd10, 16'd7, 16'd7, 16'd9, 16'd1},
                key: 4'b1001, ch0: 4'd3, ch1: 4'd4};
    vecs[1] = '{first: 4'd15,
                resp: {16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd255, 16'd254},
                key: 4'b0101, ch0: 4'd15, ch1: 4'd0};
    vecs[2] = '{first: 4'd7,
                resp: {16'd200, 16'd100, 16'd100, 16'd99, 16'd50, 16'd51, 16'd1000, 16'd999},
                key: 4'b1101, ch0: 4'd7, ch1: 4'd8};

    reset = 1'b0;
    req_valid = 1'b0;
    req_first_ch = '0;
    abort = 1'b0;
    puf_response = '0;
    store_response_puf = 1'b0;
    puf_done = 1'b0;
    key_ready = 1'b0;
    tick();
    tick();
    check("rst_start_puf", start_puf, 0);
    check("rst_challenge", challenge, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_data", key_data, 0);
    check("rst_key_error", key_error, 0);
    reset = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);

    // Pulses outside RUN are ignored.
    s = start_cnt;
    pulse_store(16'd5);
    pulse_done();
    check("idle_pulses_no_start", start_cnt - s, 0);
    check("idle_pulses_stay_idle", req_ready, 1);

    // Table-driven full transactions.
    for (int v = 0; v < 3; v++) begin
      s = start_cnt;
      request(vecs[v].first);
      wait_start(vecs[v].ch0);
      for (int k = 0; k < 4; k++) pulse_store(vecs[v].resp[k]);
      pulse_done();
      wait_start(vecs[v].ch1);
      for (int k = 4; k < 8; k++) pulse_store(vecs[v].resp[k]);
      pulse_done();
      wait_key();
      check("vec_key_data", key_data, vecs[v].key);
      check("vec_key_error", key_error, 0);
      check("vec_start_count", start_cnt - s, 2);
      release_key();
    end

    // Done after only three stores.
    s = start_cnt;
    request(4'd0);
    wait_start(4'd0);
    pulse_store(16'd5);
    pulse_store(16'd3);
    pulse_store(16'd8);
    pulse_done();
    wait_key();
    check("short_key_error", key_error, 1);
    for (int i = 0; i < 5; i++) tick();
    check("short_no_more_start", start_cnt - s, 1);
    check("short_key_valid_held", key_valid, 1);
    release_key();

    // Store and done together on the last bit, then key held for 10 cycles.
    request(4'd5);
    wait_start(4'd5);
    pulse_store(16'd10);
    pulse_store(16'd5);
    pulse_store(16'd5);
    pulse_store(16'd10);
    pulse_done();
    wait_start(4'd6);
    pulse_store(16'd7);
    pulse_store(16'd7);
    pulse_store(16'd9);
    store_response_puf = 1'b1;
    puf_done = 1'b1;
    puf_response = 16'd1;
    tick();
    store_response_puf = 1'b0;
    puf_done = 1'b0;
    wait_key();
    check("same_cycle_key_data", key_data, 4'b1001);
    check("same_cycle_key_error", key_error, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_key_valid", key_valid, 1);
      check("hold_key_data", key_data, 4'b1001);
    end
    release_key();

    // Abort during RUN.
    s = start_cnt;
    request(4'd2);
    wait_start(4'd2);
    pulse_store(16'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_idle", req_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (key_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    check("abort_key_valid_never", seen, 0);
    check("abort_start_count", start_cnt - s, 1);

    // Abort while in LAUNCH suppresses the start pulse.
    s = start_cnt;
    request(4'd1);
    abort = 1'b1;
    #1;
    check("abort_launch_start_puf", start_puf, 0);
    tick();
    abort = 1'b0;
    check("abort_launch_idle", req_ready, 1);
    check("abort_launch_no_start", start_cnt - s, 0);

    // Watchdog expiry with no PUF activity.
    request(4'd11);
    wait_start(4'd11);
    n = 0;
    while (key_valid !== 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("timeout_run_cycles", n, 15);
    check("timeout_key_error", key_error, 1);
    release_key();

    // Reset in the middle of RUN.
    s = start_cnt;
    request(4'd9);
    wait_start(4'd9);
    pulse_store(16'd3);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_start_puf", start_puf, 0);
    check("midrst_challenge", challenge, 0);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_key_data", key_data, 0);
    check("midrst_key_error", key_error, 0);
    check("midrst_req_ready", req_ready, 1);
    tick();
    reset = 1'b1;
    tick();
    check("postrst_req_ready", req_ready, 1);
    check("postrst_start_count", start_cnt - s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
